// File: rtl/cnn_pool_pkg.sv
// rtl/cnn_pool_pkg.sv - shared types, defaults and helpers for the 2x2 max-pooling stage
package cnn_pool_pkg;

   localparam int POOL_DATA_W  = 16;
   localparam int POOL_MAX_DIM = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } pool_state_t;

   typedef logic signed [POOL_DATA_W-1:0] pool_data_t;

   function automatic pool_data_t smax(input pool_data_t a, input pool_data_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_line_buf.sv
// rtl/pool_line_buf.sv - half-row buffer of even-row pair maxima, one write port and async read
module pool_line_buf #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 32,
   parameter int AW     = 5
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [AW-1:0]            addr,
   input  logic signed [DATA_W-1:0] wdata,
   output logic signed [DATA_W-1:0] rdata
);

   logic signed [DATA_W-1:0] mem [DEPTH];

   // Store the even-row pair maximum until the matching odd-row pair arrives
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/max_pool_2x2.sv
// rtl/max_pool_2x2.sv - 2x2 stride-2 max pooling of a row-major conv stream (POOL_RELU_EN fuses ReLU)
module max_pool_2x2
   import cnn_pool_pkg::*;
#(
   parameter int DATA_W  = POOL_DATA_W,
   parameter int MAX_DIM = POOL_MAX_DIM
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     pooling_ctrl,
   input  logic [6:0]               fmap_dim,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     pooling_finish
);

   localparam int         LB_DEPTH  = MAX_DIM / 2;
   localparam int         LB_AW     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam logic [6:0] MAX_DIM_C = 7'(MAX_DIM);

   pool_state_t       state;
   logic [6:0]        dim_q;
   logic [6:0]        col;
   logic [6:0]        row;
   pool_data_t        hold_q;
   pool_data_t        lbuf_rdata;
   pool_data_t        pair_max;
   pool_data_t        win_max;
   logic [6:0]        dim_clamped;
   logic              accept;
   logic              last_col;
   logic              last_row;
   logic              lbuf_we;
   logic [LB_AW-1:0]  lbuf_addr;

   function automatic pool_data_t post_act(input pool_data_t v);
`ifdef POOL_RELU_EN
      return (v < 0) ? '0 : v;
`else
      return v;
`endif
   endfunction

   // Oversized maps are clamped so the line buffer is never overrun
   assign dim_clamped = (fmap_dim > MAX_DIM_C) ? MAX_DIM_C : fmap_dim;
   assign accept      = (state == RUN) && pooling_ctrl && in_valid;
   assign last_col    = (col == dim_q - 7'd1);
   assign last_row    = (row == dim_q - 7'd1);
   assign lbuf_addr   = col[LB_AW:1];
   assign pair_max    = smax(hold_q, in_data);
   assign win_max     = smax(pair_max, lbuf_rdata);
   assign lbuf_we     = accept && col[0] && !row[0];

   pool_line_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (LB_DEPTH),
      .AW     (LB_AW)
   ) u_line_buf (
      .clk   (clk),
      .we    (lbuf_we),
      .addr  (lbuf_addr),
      .wdata (pair_max),
      .rdata (lbuf_rdata)
   );

   // Control FSM, position counters, pair hold register and registered outputs
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state          <= IDLE;
         dim_q          <= '0;
         col            <= '0;
         row            <= '0;
         hold_q         <= '0;
         out_valid      <= 1'b0;
         out_data       <= '0;
         pooling_finish <= 1'b0;
      end else begin
         out_valid      <= 1'b0;
         pooling_finish <= 1'b0;
         case (state)
            IDLE: begin
               if (pooling_ctrl) begin
                  dim_q <= dim_clamped;
                  col   <= '0;
                  row   <= '0;
                  if (dim_clamped < 7'd2) begin
                     state          <= DONE;
                     pooling_finish <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (!pooling_ctrl) begin
                  state <= IDLE;
                  col   <= '0;
                  row   <= '0;
               end else if (in_valid) begin
                  if (!col[0]) begin
                     hold_q <= in_data;
                  end else if (row[0]) begin
                     out_valid <= 1'b1;
                     out_data  <= post_act(win_max);
                  end
                  if (last_col) begin
                     col <= '0;
                     row <= row + 7'd1;
                  end else begin
                     col <= col + 7'd1;
                  end
                  // Odd sizes still consume the trailing row/column before finishing
                  if (last_col && last_row) begin
                     state          <= DONE;
                     pooling_finish <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // accept is consumed inside the FSM through the same terms; keep it for the buffer write
   logic unused_ok;
   assign unused_ok = accept;

endmodule

// File: tb/tb_max_pool_2x2.sv
// tb/tb_max_pool_2x2.sv - directed table-driven bench for max_pool_2x2
module tb_max_pool_2x2;

   typedef struct packed {
      logic [6:0]        dim;
      logic              toggle;
      logic [24:0][15:0] din;
      logic [2:0]        n_exp;
      logic [3:0][15:0]  exp_v;
      logic [3:0][4:0]   exp_el;
   } vec_t;

   logic               clk = 1'b0;
   logic               nrst = 1'b0;
   logic               pooling_ctrl = 1'b0;
   logic [6:0]         fmap_dim = '0;
   logic               in_valid = 1'b0;
   logic signed [15:0] in_data = '0;
   logic               out_valid;
   logic signed [15:0] out_data;
   logic               pooling_finish;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic signed [15:0] ov_data[$];
   int                 ov_cyc[$];
   int                 fin_cyc[$];
   int                 acc[0:4095];
   vec_t               vecs[4];

   max_pool_2x2 dut (
      .clk            (clk),
      .nrst           (nrst),
      .pooling_ctrl   (pooling_ctrl),
      .fmap_dim       (fmap_dim),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .pooling_finish (pooling_finish)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (nrst) begin
         if (out_valid) begin
            ov_data.push_back(out_data);
            ov_cyc.push_back(cyc);
         end
         if (pooling_finish) fin_cyc.push_back(cyc);
      end
   end

   function automatic logic signed [15:0] exp_act(input logic signed [15:0] v);
`ifdef POOL_RELU_EN
      return (v < 0) ? 16'sd0 : v;
`else
      return v;
`endif
   endfunction

   task automatic chk(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic clear_log();
      ov_data.delete();
      ov_cyc.delete();
      fin_cyc.delete();
   endtask

   task automatic start(input int d);
      pooling_ctrl = 1'b1;
      fmap_dim     = 7'(d);
      in_valid     = 1'b0;
      @(negedge clk);
      fmap_dim = 7'd3;
   endtask

   task automatic send(input logic signed [15:0] v, output int c);
      in_valid = 1'b1;
      in_data  = v;
      @(negedge clk);
      c        = cyc;
      in_valid = 1'b0;
   endtask

   task automatic idle_beat();
      in_valid = 1'b0;
      in_data  = 16'sh7fff;
      @(negedge clk);
   endtask

   task automatic finish_and_release();
      for (int k = 0; k < 4 && !pooling_finish; k++) @(negedge clk);
      pooling_ctrl = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int n;
      int bad;
      int dummy;

      for (int v = 0; v < 4; v++) vecs[v] = '0;
      vecs[0].dim = 7'd4;
      for (int k = 0; k < 16; k++) vecs[0].din[k] = 16'(k);
      vecs[0].n_exp = 3'd4;
      vecs[0].exp_v[0] = 16'd5;  vecs[0].exp_v[1] = 16'd7;
      vecs[0].exp_v[2] = 16'd13; vecs[0].exp_v[3] = 16'd15;
      vecs[0].exp_el[0] = 5'd5;  vecs[0].exp_el[1] = 5'd7;
      vecs[0].exp_el[2] = 5'd13; vecs[0].exp_el[3] = 5'd15;

      vecs[1] = vecs[0];
      for (int k = 0; k < 16; k++) vecs[1].din[k] = 16'(-100);
      vecs[1].din[9] = 16'(-3);
      vecs[1].exp_v[0] = 16'(-100); vecs[1].exp_v[1] = 16'(-100);
      vecs[1].exp_v[2] = 16'(-3);   vecs[1].exp_v[3] = 16'(-100);

      vecs[2].dim = 7'd5;
      for (int k = 0; k < 25; k++) vecs[2].din[k] = 16'(k);
      vecs[2].n_exp = 3'd4;
      vecs[2].exp_v[0] = 16'd6;  vecs[2].exp_v[1] = 16'd8;
      vecs[2].exp_v[2] = 16'd16; vecs[2].exp_v[3] = 16'd18;
      vecs[2].exp_el[0] = 5'd6;  vecs[2].exp_el[1] = 5'd8;
      vecs[2].exp_el[2] = 5'd16; vecs[2].exp_el[3] = 5'd18;

      vecs[3] = vecs[0];
      vecs[3].toggle = 1'b1;

      repeat (2) @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_finish", pooling_finish, 0);
      nrst = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 4; v++) begin
         clear_log();
         start(int'(vecs[v].dim));
         n = int'(vecs[v].dim) * int'(vecs[v].dim);
         for (int k = 0; k < n; k++) begin
            if (vecs[v].toggle && k > 0) idle_beat();
            send($signed(vecs[v].din[k]), acc[k]);
         end
         finish_and_release();
         chk($sformatf("v%0d_out_count", v), ov_data.size(), int'(vecs[v].n_exp));
         for (int j = 0; j < int'(vecs[v].n_exp); j++) begin
            if (j < ov_data.size()) begin
               chk($sformatf("v%0d_data%0d", v, j), ov_data[j], exp_act($signed(vecs[v].exp_v[j])));
               chk($sformatf("v%0d_cycle%0d", v, j), ov_cyc[j], acc[vecs[v].exp_el[j]]);
            end
         end
         chk($sformatf("v%0d_finish_count", v), fin_cyc.size(), 1);
         if (fin_cyc.size() > 0) chk($sformatf("v%0d_finish_cycle", v), fin_cyc[0], acc[n-1]);
      end

      // Abort after six elements, then a clean 2x2 map
      clear_log();
      start(4);
      for (int k = 0; k < 6; k++) send(16'(k), acc[k]);
      pooling_ctrl = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_out_count", ov_data.size(), 1);
      if (ov_data.size() > 0) begin
         chk("abort_data", ov_data[0], 5);
         chk("abort_cycle", ov_cyc[0], acc[5]);
      end
      chk("abort_finish_count", fin_cyc.size(), 0);

      clear_log();
      start(2);
      send(16'sd3, acc[0]);
      send(16'sd9, acc[1]);
      send(-16'sd1, acc[2]);
      send(16'sd4, acc[3]);
      finish_and_release();
      chk("restart_out_count", ov_data.size(), 1);
      if (ov_data.size() > 0) begin
         chk("restart_data", ov_data[0], 9);
         chk("restart_cycle", ov_cyc[0], acc[3]);
      end
      chk("restart_finish_count", fin_cyc.size(), 1);
      if (fin_cyc.size() > 0) chk("restart_finish_cycle", fin_cyc[0], acc[3]);

      // Oversized dimension clamps to the full 64x64 map
      clear_log();
      start(100);
      for (int r = 0; r < 64; r++)
         for (int c = 0; c < 64; c++) send(16'(r * 64 + c), dummy);
      finish_and_release();
      chk("clamp_out_count", ov_data.size(), 1024);
      bad = 0;
      for (int j = 0; j < ov_data.size() && j < 1024; j++)
         if (ov_data[j] != 16'(((j / 32) * 2 + 1) * 64 + (j % 32) * 2 + 1)) bad++;
      chk("clamp_value_mismatches", bad, 0);
      chk("clamp_finish_count", fin_cyc.size(), 1);

      // Asynchronous reset in the middle of a map
      clear_log();
      start(4);
      for (int k = 0; k < 6; k++) send(16'(k), acc[k]);
      chk("prereset_out_valid", out_valid, 1);
      chk("prereset_out_data", out_data, 5);
      #2;
      nrst = 1'b0;
      pooling_ctrl = 1'b0;
      #1;
      chk("async_reset_out_valid", out_valid, 0);
      chk("async_reset_out_data", out_data, 0);
      chk("async_reset_finish", pooling_finish, 0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);

      clear_log();
      start(2);
      send(-16'sd5, acc[0]);
      send(-16'sd7, acc[1]);
      send(-16'sd2, acc[2]);
      send(-16'sd9, acc[3]);
      finish_and_release();
      chk("postreset_out_count", ov_data.size(), 1);
      if (ov_data.size() > 0) begin
         chk("postreset_data", ov_data[0], exp_act(-16'sd2));
         chk("postreset_cycle", ov_cyc[0], acc[3]);
      end
      chk("postreset_finish_count", fin_cyc.size(), 1);

      clear_log();
      start(1);
      finish_and_release();
      chk("dim1_out_count", ov_data.size(), 0);
      chk("dim1_finish_count", fin_cyc.size(), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
